io_fifo: RTL and testbench

Parametrised synchronous FIFO for the io_hub datapath. It generalises the hub's basic buffer with:
- configurable width and depth;
- a selectable first-word-fall-through (FWFT) read mode;
- almost-full / almost-empty thresholds and an occupancy count;
- optional sticky overflow/underflow error flags.

It sits between io_hub producers (e.g. UART/SPI receive paths) and consumers that need back-pressure with early warning.

---
 rtl/io_fifo.sv | 132 +++++++++++++
 tb/tb_io_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/io_fifo.sv
// io_fifo: parametrised synchronous FIFO with selectable standard/FWFT read
// mode, almost-full/almost-empty thresholds and an occupancy count.
// Optional sticky overflow/underflow flags are compiled in when the macro
// IO_FIFO_ERR_EN is defined; otherwise they are tied low and err_clr is unused.
module io_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned AFULL_THR  = 3,
  parameter int unsigned AEMPTY_THR = 1,
  parameter int unsigned FWFT       = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  din,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  dout,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  input  logic              err_clr,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CW    = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THR);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THR);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_acc;
  logic              rd_acc;

  // Accept decode: a pop frees the slot for a same-cycle write at full,
  // but a same-cycle write never makes a read of an empty FIFO valid.
  always_comb begin
    rd_acc = rd_en && !empty;
    wr_acc = wr_en && (!full || rd_acc);
  end

  // Status flags decoded from the registered occupancy.
  always_comb begin
    empty        = (count == '0);
    full         = (count == DEPTH_C);
    almost_empty = (count <= AEMPTY_C);
    almost_full  = (count >= AFULL_C);
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally; count moves only when exactly one side is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of queue shown combinationally; forced to zero while empty so
      // the reset value of dout is still zero.
      always_comb begin
        dout = empty ? '0 : mem[rd_ptr];
      end
    end else begin : g_std
      // Registered read port; holds its value on idle and rejected reads.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout <= '0;
        end else if (rd_acc) begin
          dout <= mem[rd_ptr];
        end
      end
    end
  endgenerate

`ifdef IO_FIFO_ERR_EN
  // Sticky error flags; a new error in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_acc) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (rd_en && !rd_acc) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end
`else
  logic unused_err_clr;

  // Error reporting compiled out: flags tied low, err_clr has no effect.
  always_comb begin
    overflow       = 1'b0;
    underflow      = 1'b0;
    unused_err_clr = err_clr;
  end
`endif

endmodule

// File: tb/tb_io_fifo.sv
// Testbench for io_fifo: one standard-mode and one FWFT-mode instance share
// the same stimulus and are checked every cycle against a queue-based model,
// plus directed literal checks following the test plan.
module tb_io_fifo;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned ADDR_W     = 2;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned AFULL_THR  = 3;
  localparam int unsigned AEMPTY_THR = 1;
`ifdef IO_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             rd_en = 1'b0;
  logic             err_clr = 1'b0;

  logic [WIDTH-1:0] dout_s, dout_f;
  logic             empty_s, full_s, ae_s, af_s, ovf_s, unf_s;
  logic             empty_f, full_f, ae_f, af_f, ovf_f, unf_f;
  logic [ADDR_W:0]  count_s, count_f;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  io_fifo #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .AFULL_THR(AFULL_THR),
            .AEMPTY_THR(AEMPTY_THR), .FWFT(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout_s), .empty(empty_s), .full(full_s), .almost_empty(ae_s),
    .almost_full(af_s), .count(count_s), .err_clr(err_clr),
    .overflow(ovf_s), .underflow(unf_s));

  io_fifo #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .AFULL_THR(AFULL_THR),
            .AEMPTY_THR(AEMPTY_THR), .FWFT(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout_f), .empty(empty_f), .full(full_f), .almost_empty(ae_f),
    .almost_full(af_f), .count(count_f), .err_clr(err_clr),
    .overflow(ovf_f), .underflow(unf_f));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, standard dout as last popped word.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_dout;
  bit               m_ovf, m_unf;
  bit               m_rd_ok, m_wr_ok;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      m_rd_ok = rd_en && (mq.size() > 0);
      m_wr_ok = wr_en && ((mq.size() < DEPTH) || m_rd_ok);
      if (ERR_EN) begin
        if (wr_en && !m_wr_ok) m_ovf = 1'b1;
        else if (err_clr)      m_ovf = 1'b0;
        if (rd_en && !m_rd_ok) m_unf = 1'b1;
        else if (err_clr)      m_unf = 1'b0;
      end
      if (m_rd_ok) m_dout = mq.pop_front();
      if (m_wr_ok) mq.push_back(din);
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("count_s", 32'(count_s), 32'(mq.size()));
    chk("count_f", 32'(count_f), 32'(mq.size()));
    chk("empty_s", 32'(empty_s), 32'(mq.size() == 0));
    chk("empty_f", 32'(empty_f), 32'(mq.size() == 0));
    chk("full_s",  32'(full_s),  32'(mq.size() == DEPTH));
    chk("full_f",  32'(full_f),  32'(mq.size() == DEPTH));
    chk("aempty_s", 32'(ae_s), 32'(mq.size() <= AEMPTY_THR));
    chk("aempty_f", 32'(ae_f), 32'(mq.size() <= AEMPTY_THR));
    chk("afull_s",  32'(af_s), 32'(mq.size() >= AFULL_THR));
    chk("afull_f",  32'(af_f), 32'(mq.size() >= AFULL_THR));
    chk("ovf_s", 32'(ovf_s), 32'(m_ovf));
    chk("ovf_f", 32'(ovf_f), 32'(m_ovf));
    chk("unf_s", 32'(unf_s), 32'(m_unf));
    chk("unf_f", 32'(unf_f), 32'(m_unf));
    chk("dout_s", 32'(dout_s), 32'(m_dout));
    if (mq.size() > 0) chk("dout_f", 32'(dout_f), 32'(mq[0]));
  end

  // Apply inputs for one clock edge, return just after the following negedge.
  task automatic step(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit c);
    wr_en = w; din = d; rd_en = r; err_clr = c;
    @(negedge clk); #1;
  endtask

  initial begin
    int pw, pr;
    @(negedge clk); #1;
    step(0, 8'h00, 0, 0);
    chk("rst_count", 32'(count_s), 0);
    chk("rst_empty", 32'(empty_s), 1);
    chk("rst_full",  32'(full_s), 0);
    chk("rst_ae",    32'(ae_s), 1);
    chk("rst_af",    32'(af_s), 0);
    chk("rst_dout_s", 32'(dout_s), 0);
    chk("rst_dout_f", 32'(dout_f), 0);
    rst_n = 1'b1;

    // Fill with threshold crossings.
    step(1, 8'h11, 0, 0);
    chk("fill1_ae", 32'(ae_s), 1);
    chk("fill1_dout_f", 32'(dout_f), 32'h11);
    step(1, 8'h22, 0, 0);
    chk("fill2_ae", 32'(ae_s), 0);
    chk("fill2_af", 32'(af_s), 0);
    step(1, 8'h33, 0, 0);
    chk("fill3_af", 32'(af_s), 1);
    step(1, 8'h44, 0, 0);
    chk("fill4_count", 32'(count_s), 4);
    chk("fill4_full",  32'(full_s), 1);
    chk("fill4_af",    32'(af_s), 1);

    // Simultaneous write+read at full.
    step(1, 8'h55, 1, 0);
    chk("fullrw_count", 32'(count_s), 4);
    chk("fullrw_ovf",   32'(ovf_s), 0);
    chk("fullrw_dout",  32'(dout_s), 32'h11);
    step(0, 8'h00, 1, 0); chk("drain_22", 32'(dout_s), 32'h22);
    step(0, 8'h00, 1, 0); chk("drain_33", 32'(dout_s), 32'h33);
    step(0, 8'h00, 1, 0); chk("drain_44", 32'(dout_s), 32'h44);
    step(0, 8'h00, 1, 0); chk("drain_55", 32'(dout_s), 32'h55);
    chk("drain_empty", 32'(empty_s), 1);

    // Simultaneous write+read at empty.
    step(1, 8'hA5, 1, 0);
    chk("emptyrw_count", 32'(count_s), 1);
    chk("emptyrw_unf",   32'(unf_s), 32'(ERR_EN));
    chk("emptyrw_dout_s", 32'(dout_s), 32'h55);
    chk("emptyrw_dout_f", 32'(dout_f), 32'hA5);

    // Overflow, then clear.
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    step(1, 8'h03, 0, 0);
    step(1, 8'h77, 0, 0);
    chk("ovf_count", 32'(count_s), 4);
    chk("ovf_flag",  32'(ovf_s), 32'(ERR_EN));
    step(0, 8'h00, 0, 1);
    chk("clr_ovf", 32'(ovf_s), 0);
    chk("clr_unf", 32'(unf_s), 0);
    step(0, 8'h00, 1, 0); chk("odrain_a5", 32'(dout_s), 32'hA5);
    step(0, 8'h00, 1, 0); chk("odrain_01", 32'(dout_s), 32'h01);
    step(0, 8'h00, 1, 0); chk("odrain_02", 32'(dout_s), 32'h02);
    step(0, 8'h00, 1, 0); chk("odrain_03", 32'(dout_s), 32'h03);

    // FWFT visibility and pop-with-write.
    step(1, 8'h3C, 0, 0);
    chk("fwft_3c", 32'(dout_f), 32'h3C);
    step(1, 8'h3D, 1, 0);
    chk("fwft_3d", 32'(dout_f), 32'h3D);
    chk("fwft_count", 32'(count_f), 1);

    // Asynchronous reset mid-stream at count 3.
    step(1, 8'h61, 0, 0);
    step(1, 8'h62, 0, 0);
    chk("pre_rst_count", 32'(count_s), 3);
    wr_en = 1'b0; rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_count",  32'(count_s), 0);
    chk("arst_empty",  32'(empty_s), 1);
    chk("arst_dout_s", 32'(dout_s), 0);
    chk("arst_dout_f", 32'(dout_f), 0);
    chk("arst_ovf",    32'(ovf_s), 0);
    chk("arst_unf",    32'(unf_s), 0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Sustained write+read across pointer wrap.
    step(1, 8'h80, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 8'(8'h90 + i), 1, 0);
      chk("wrap_dout", 32'(dout_s), (i == 0) ? 32'h80 : 32'(8'h90 + i - 1));
      chk("wrap_count", 32'(count_s), 1);
    end

    // Randomized phases: write-heavy, read-heavy, balanced.
    for (int ph = 0; ph < 6; ph++) begin
      case (ph % 3)
        0:       begin pw = 80; pr = 25; end
        1:       begin pw = 25; pr = 80; end
        default: begin pw = 60; pr = 60; end
      endcase
      for (int k = 0; k < 400; k++) begin
        step($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
             $urandom_range(0, 99) < 5);
      end
    end
    step(0, 8'h00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
